key_debounce_repeat: RTL and testbench

//   Consumer side of the enable_gen strobe. Samples raw calculator push-buttons

---
 rtl/key_debounce_repeat.sv | 173 +++++++++++++++++
 tb/tb_key_debounce_repeat.sv | 380 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/key_debounce_repeat.sv
// -----------------------------------------------------------------------------
// key_debounce_repeat
//   Samples raw push-button levels through a two-flop synchroniser. On each
//   enable tick it debounces every key independently. It emits a one-clock
//   press pulse when a key is accepted as pressed. While the key stays held it
//   can also emit auto-repeat pulses.
//
// Ports
//   clk        in   1         system clock, all state on the rising edge
//   reset      in   1         asynchronous active-low reset, clears all state
//   enable     in   1         sample strobe; debounce/repeat advance only here
//   key_raw    in   NUM_KEYS  asynchronous button levels, 1 = pressed
//   key_state  out  NUM_KEYS  debounced level per key
//   key_pulse  out  NUM_KEYS  1-clk pulse per accepted press or repeat
//   key_busy   out  1         OR of key_state
// -----------------------------------------------------------------------------
module key_debounce_repeat #(
  parameter int NUM_KEYS     = 4,
  parameter int DEBOUNCE_CNT = 4,
  parameter int REPEAT_DELAY = 20,
  parameter int REPEAT_RATE  = 5,
  parameter int REPEAT_EN    = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  input  logic [NUM_KEYS-1:0] key_raw,
  output logic [NUM_KEYS-1:0] key_state,
  output logic [NUM_KEYS-1:0] key_pulse,
  output logic                key_busy
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DELAY  = 2'd1,
    ST_REPEAT = 2'd2
  } state_t;

  // Terminal counts; every counter is cleared on match, so none can wrap.
  localparam logic [7:0] L_DB_LAST = 8'(DEBOUNCE_CNT - 1);
  localparam logic [7:0] L_RD_LAST = 8'(REPEAT_DELAY - 1);
  localparam logic [7:0] L_RR_LAST = 8'(REPEAT_RATE - 1);

  logic [NUM_KEYS-1:0] r_sync1;
  logic [NUM_KEYS-1:0] r_sync2;
  logic [NUM_KEYS-1:0] r_level;
  logic [NUM_KEYS-1:0] r_pulse;
  logic                r_busy;
  logic [7:0]          r_db_cnt   [NUM_KEYS];
  logic [7:0]          r_hold_cnt [NUM_KEYS];
  state_t              r_fsm      [NUM_KEYS];

  logic [7:0]          w_db_cnt_nxt [NUM_KEYS];
  logic [7:0]          w_hold_nxt   [NUM_KEYS];
  state_t              w_fsm_nxt    [NUM_KEYS];
  logic [NUM_KEYS-1:0] w_level_nxt;
  logic [NUM_KEYS-1:0] w_rise;
  logic [NUM_KEYS-1:0] w_fall;
  logic [NUM_KEYS-1:0] w_pulse_nxt;

  // Two-flop synchroniser, runs every clock regardless of enable.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sync1 <= {NUM_KEYS{1'b0}};
      r_sync2 <= {NUM_KEYS{1'b0}};
    end else begin
      r_sync1 <= key_raw;
      r_sync2 <= r_sync1;
    end
  end

  // Debounce next state: a matching sample restarts the count, so the level
  // flips only after DEBOUNCE_CNT consecutive mismatching ticks.
  always_comb begin
    w_level_nxt = r_level;
    w_rise      = {NUM_KEYS{1'b0}};
    w_fall      = {NUM_KEYS{1'b0}};
    for (int k = 0; k < NUM_KEYS; k++) begin
      w_db_cnt_nxt[k] = r_db_cnt[k];
      if (!enable) begin
        w_db_cnt_nxt[k] = r_db_cnt[k];
      end else if (r_sync2[k] == r_level[k]) begin
        w_db_cnt_nxt[k] = 8'd0;
      end else if (r_db_cnt[k] == L_DB_LAST) begin
        w_db_cnt_nxt[k] = 8'd0;
        w_level_nxt[k]  = ~r_level[k];
        w_rise[k]       = ~r_level[k];
        w_fall[k]       = r_level[k];
      end else begin
        w_db_cnt_nxt[k] = r_db_cnt[k] + 8'd1;
      end
    end
  end

  // Repeat FSM next state and pulse generation. Release is tested first so it
  // suppresses a repeat pulse that falls due on the same tick.
  always_comb begin
    w_pulse_nxt = w_rise;
    for (int k = 0; k < NUM_KEYS; k++) begin
      w_fsm_nxt[k]  = r_fsm[k];
      w_hold_nxt[k] = r_hold_cnt[k];
      case (r_fsm[k])
        ST_IDLE: begin
          w_hold_nxt[k] = 8'd0;
          if (w_rise[k] && (REPEAT_EN != 0)) begin
            w_fsm_nxt[k] = ST_DELAY;
          end else begin
            w_fsm_nxt[k] = ST_IDLE;
          end
        end
        ST_DELAY: begin
          if (w_fall[k]) begin
            w_fsm_nxt[k]  = ST_IDLE;
            w_hold_nxt[k] = 8'd0;
          end else if (enable && (r_hold_cnt[k] == L_RD_LAST)) begin
            w_pulse_nxt[k] = 1'b1;
            w_hold_nxt[k]  = 8'd0;
            w_fsm_nxt[k]   = ST_REPEAT;
          end else if (enable) begin
            w_hold_nxt[k] = r_hold_cnt[k] + 8'd1;
          end else begin
            w_hold_nxt[k] = r_hold_cnt[k];
          end
        end
        ST_REPEAT: begin
          if (w_fall[k]) begin
            w_fsm_nxt[k]  = ST_IDLE;
            w_hold_nxt[k] = 8'd0;
          end else if (enable && (r_hold_cnt[k] == L_RR_LAST)) begin
            w_pulse_nxt[k] = 1'b1;
            w_hold_nxt[k]  = 8'd0;
          end else if (enable) begin
            w_hold_nxt[k] = r_hold_cnt[k] + 8'd1;
          end else begin
            w_hold_nxt[k] = r_hold_cnt[k];
          end
        end
        default: begin
          w_fsm_nxt[k]  = ST_IDLE;
          w_hold_nxt[k] = 8'd0;
        end
      endcase
    end
  end

  // State registers for debounce, repeat FSM and the registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_level <= {NUM_KEYS{1'b0}};
      r_pulse <= {NUM_KEYS{1'b0}};
      r_busy  <= 1'b0;
      for (int k = 0; k < NUM_KEYS; k++) begin
        r_db_cnt[k]   <= 8'd0;
        r_hold_cnt[k] <= 8'd0;
        r_fsm[k]      <= ST_IDLE;
      end
    end else begin
      r_level <= w_level_nxt;
      r_pulse <= w_pulse_nxt;
      r_busy  <= |w_level_nxt;
      for (int k = 0; k < NUM_KEYS; k++) begin
        r_db_cnt[k]   <= w_db_cnt_nxt[k];
        r_hold_cnt[k] <= w_hold_nxt[k];
        r_fsm[k]      <= w_fsm_nxt[k];
      end
    end
  end

  assign key_state = r_level;
  assign key_pulse = r_pulse;
  assign key_busy  = r_busy;

endmodule

// File: tb/tb_key_debounce_repeat.sv
// -----------------------------------------------------------------------------
// tb_key_debounce_repeat
//   Drives two copies of key_debounce_repeat, one with auto-repeat and one
//   without. Both copies share the same inputs. Every clock, their outputs are
//   compared against a reference model. The model tracks a sliding window of
//   tick samples per key and counts ticks since acceptance.
// -----------------------------------------------------------------------------
module tb_key_debounce_repeat;

  localparam int NK = 4;
  localparam int DB = 4;
  localparam int RD = 20;
  localparam int RR = 5;

  logic          clk     = 1'b0;
  logic          reset   = 1'b0;
  logic          enable  = 1'b0;
  logic [NK-1:0] key_raw = '0;
  logic [NK-1:0] key_state, key_pulse, nr_state, nr_pulse;
  logic          key_busy, nr_busy;
  logic [17:0]   obs_vec;
  logic [17:0]   exp_vec = '0;

  int vectors     = 0;
  int miscompares = 0;

  // model state
  int            en_mode  = 0;   // 0 tied high, 1 every 5 clk, 2 random
  int            en_phase = 0;
  int            tick_cnt = 0;
  bit            last_tick = 1'b0;
  logic [NK-1:0] raw_d1 = '0, raw_d2 = '0;
  logic [NK-1:0] m_state = '0, m_pulse = '0, m_pulse_nr = '0;
  int            m_n [NK];
  bit            win_q [NK][$];

  always #5 clk = ~clk;

  key_debounce_repeat #(.NUM_KEYS(NK), .DEBOUNCE_CNT(DB), .REPEAT_DELAY(RD),
                        .REPEAT_RATE(RR), .REPEAT_EN(1)) u_dut (
    .clk(clk), .reset(reset), .enable(enable), .key_raw(key_raw),
    .key_state(key_state), .key_pulse(key_pulse), .key_busy(key_busy));

  key_debounce_repeat #(.NUM_KEYS(NK), .DEBOUNCE_CNT(DB), .REPEAT_DELAY(RD),
                        .REPEAT_RATE(RR), .REPEAT_EN(0)) u_norep (
    .clk(clk), .reset(reset), .enable(enable), .key_raw(key_raw),
    .key_state(nr_state), .key_pulse(nr_pulse), .key_busy(nr_busy));

  assign obs_vec = {key_state, key_pulse, key_busy, nr_state, nr_pulse, nr_busy};

  // Reference behaviour at one rising edge, using the pre-edge inputs.
  task automatic model_edge();
    logic [NK-1:0] samp;
    bit flip;
    m_pulse    = '0;
    m_pulse_nr = '0;
    if (!reset) begin
      raw_d1 = '0; raw_d2 = '0; m_state = '0; last_tick = 1'b0;
      for (int k = 0; k < NK; k++) begin
        win_q[k].delete();
        m_n[k] = 0;
      end
    end else begin
      samp      = raw_d2;
      last_tick = enable;
      if (enable) begin
        tick_cnt++;
        for (int k = 0; k < NK; k++) begin
          win_q[k].push_back(samp[k]);
          if (win_q[k].size() > DB) void'(win_q[k].pop_front());
          // accept a change once the last DB tick samples all show it
          flip = (win_q[k].size() == DB);
          for (int j = 0; j < win_q[k].size(); j++)
            if (win_q[k][j] == m_state[k]) flip = 1'b0;
          if (flip && !m_state[k]) begin
            m_state[k] = 1'b1; m_n[k] = 0; m_pulse[k] = 1'b1; m_pulse_nr[k] = 1'b1;
          end else if (flip) begin
            m_state[k] = 1'b0;
          end else if (m_state[k]) begin
            m_n[k]++;
            if (m_n[k] == RD || (m_n[k] > RD && (m_n[k] - RD) % RR == 0))
              m_pulse[k] = 1'b1;
          end
        end
      end
      raw_d2 = raw_d1;
      raw_d1 = key_raw;
    end
    exp_vec = {m_state, m_pulse, |m_state, m_state, m_pulse_nr, |m_state};
  endtask

  task automatic set_mode(input int m);
    en_mode  = m;
    en_phase = 0;
    enable   = (m == 2) ? 1'($urandom_range(0, 1)) : 1'b1;
  endtask

  // One clock: model follows the edge, then the next enable value is driven.
  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    case (en_mode)
      0: enable = 1'b1;
      1: begin en_phase = (en_phase + 1) % 5; enable = (en_phase == 0); end
      default: enable = 1'($urandom_range(0, 1));
    endcase
  endtask

  task automatic test_reset();
    set_mode(0);
    key_raw = 4'b1111;
    #1;
    vectors++;
    if (obs_vec !== 18'd0) begin miscompares++; $display("FAIL reset_initial got %b want 0", obs_vec); end
    for (int i = 1; i <= 3; i++) begin
      step();
      vectors++;
      if (obs_vec !== exp_vec) begin miscompares++; $display("FAIL reset_hold cyc %0d got %b want %b", i, obs_vec, exp_vec); end
    end
    reset = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      step();
      vectors++;
      if (obs_vec !== exp_vec) begin miscompares++; $display("FAIL reset_release cyc %0d got %b want %b", i, obs_vec, exp_vec); end
      if (i == 6) begin
        vectors++;
        if (nr_pulse !== 4'b1111) begin miscompares++; $display("FAIL reset_press_pulse got %b want 1111", nr_pulse); end
      end
    end
    key_raw = '0;
    for (int i = 1; i <= 12; i++) begin
      step();
      vectors++;
      if (obs_vec !== exp_vec) begin miscompares++; $display("FAIL reset_settle cyc %0d got %b want %b", i, obs_vec, exp_vec); end
    end
  endtask

  task automatic test_clean_press();
    int pulses_nr = 0;
    logic want;
    set_mode(0);
    key_raw[0] = 1'b1;
    for (int i = 1; i <= 30; i++) begin
      step();
      vectors++;
      if (obs_vec !== exp_vec) begin miscompares++; $display("FAIL clean_press cyc %0d got %b want %b", i, obs_vec, exp_vec); end
      pulses_nr += nr_pulse[0] ? 1 : 0;
      if (i == 5 || i == 6) begin
        want = (i == 6) ? 1'b1 : 1'b0;
        vectors++;
        if (key_state[0] !== want) begin miscompares++; $display("FAIL clean_latency cyc %0d got %b want %b", i, key_state[0], want); end
      end
    end
    vectors++;
    if (pulses_nr != 1) begin miscompares++; $display("FAIL clean_pulse_count got %0d want 1", pulses_nr); end
    key_raw[0] = 1'b0;
    for (int i = 1; i <= 12; i++) begin
      step();
      vectors++;
      if (obs_vec !== exp_vec) begin miscompares++; $display("FAIL clean_release cyc %0d got %b want %b", i, obs_vec, exp_vec); end
      if (i == 6) begin
        vectors++;
        if (key_state[0] !== 1'b0 || key_pulse[0] !== 1'b0 || nr_pulse[0] !== 1'b0) begin
          miscompares++; $display("FAIL clean_release_edge got st=%b p=%b nrp=%b want 0 0 0", key_state[0], key_pulse[0], nr_pulse[0]);
        end
      end
    end
  endtask

  task automatic test_bounce();
    int pulses_bounce = 0;
    int pulses_total = 0;
    set_mode(1);
    for (int i = 0; i < 20; i++) begin
      if (i % 2 == 0) key_raw[1] = ~key_raw[1];
      step();
      vectors++;
      if (obs_vec !== exp_vec) begin miscompares++; $display("FAIL bounce cyc %0d got %b want %b", i, obs_vec, exp_vec); end
      pulses_bounce += nr_pulse[1] ? 1 : 0;
    end
    key_raw[1] = 1'b1;
    for (int i = 0; i < 40; i++) begin
      step();
      vectors++;
      if (obs_vec !== exp_vec) begin miscompares++; $display("FAIL bounce_steady cyc %0d got %b want %b", i, obs_vec, exp_vec); end
      pulses_total += nr_pulse[1] ? 1 : 0;
    end
    vectors++;
    if (pulses_bounce != 0 || pulses_total != 1) begin
      miscompares++; $display("FAIL bounce_pulses got %0d/%0d want 0/1", pulses_bounce, pulses_total);
    end
    key_raw[1] = 1'b0;
    for (int i = 0; i < 40; i++) begin
      step();
      vectors++;
      if (obs_vec !== exp_vec) begin miscompares++; $display("FAIL bounce_release cyc %0d got %b want %b", i, obs_vec, exp_vec); end
    end
  endtask

  task automatic test_auto_repeat();
    int pulses = 0;
    int t0;
    set_mode(1);
    step();
    vectors++;
    if (obs_vec !== exp_vec) begin miscompares++; $display("FAIL repeat_align got %b want %b", obs_vec, exp_vec); end
    key_raw[2] = 1'b1;
    t0 = tick_cnt;
    while (tick_cnt - t0 < 200) begin
      step();
      vectors++;
      if (obs_vec !== exp_vec) begin miscompares++; $display("FAIL repeat_hold tick %0d got %b want %b", tick_cnt - t0, obs_vec, exp_vec); end
      pulses += key_pulse[2] ? 1 : 0;
    end
    key_raw[2] = 1'b0;
    for (int i = 0; i < 40; i++) begin
      step();
      vectors++;
      if (obs_vec !== exp_vec) begin miscompares++; $display("FAIL repeat_release cyc %0d got %b want %b", i, obs_vec, exp_vec); end
      pulses += key_pulse[2] ? 1 : 0;
    end
    vectors++;
    if (pulses != 37) begin miscompares++; $display("FAIL repeat_count got %0d want 37", pulses); end
  endtask

  task automatic test_release_in_delay();
    int pulses = 0;
    int t0;
    set_mode(1);
    step();
    vectors++;
    if (obs_vec !== exp_vec) begin miscompares++; $display("FAIL delay_align got %b want %b", obs_vec, exp_vec); end
    key_raw[0] = 1'b1;
    t0 = tick_cnt;
    while (tick_cnt - t0 < 10) begin
      step();
      vectors++;
      if (obs_vec !== exp_vec) begin miscompares++; $display("FAIL delay_hold got %b want %b", obs_vec, exp_vec); end
      pulses += key_pulse[0] ? 1 : 0;
    end
    key_raw[0] = 1'b0;
    for (int i = 0; i < 40; i++) begin
      step();
      vectors++;
      if (obs_vec !== exp_vec) begin miscompares++; $display("FAIL delay_release cyc %0d got %b want %b", i, obs_vec, exp_vec); end
      pulses += key_pulse[0] ? 1 : 0;
    end
    vectors++;
    if (pulses != 1 || key_state[0] !== 1'b0) begin
      miscompares++; $display("FAIL delay_first got pulses=%0d st=%b want 1 0", pulses, key_state[0]);
    end
    key_raw[0] = 1'b1;
    t0 = tick_cnt;
    while (tick_cnt - t0 < 22) begin
      step();
      vectors++;
      if (obs_vec !== exp_vec) begin miscompares++; $display("FAIL delay_repress got %b want %b", obs_vec, exp_vec); end
      pulses += key_pulse[0] ? 1 : 0;
    end
    vectors++;
    if (pulses != 2) begin miscompares++; $display("FAIL delay_second got %0d want 2", pulses); end
    key_raw[0] = 1'b0;
    for (int i = 0; i < 40; i++) begin
      step();
      vectors++;
      if (obs_vec !== exp_vec) begin miscompares++; $display("FAIL delay_settle cyc %0d got %b want %b", i, obs_vec, exp_vec); end
    end
  endtask

  task automatic test_reset_mid_repeat();
    int pulses = 0;
    int t0;
    set_mode(1);
    step();
    key_raw[3] = 1'b1;
    t0 = tick_cnt;
    while (tick_cnt - t0 < 35) begin
      step();
      vectors++;
      if (obs_vec !== exp_vec) begin miscompares++; $display("FAIL midrst_hold got %b want %b", obs_vec, exp_vec); end
    end
    #3;
    reset = 1'b0;
    #1;
    vectors++;
    if (obs_vec !== 18'd0) begin miscompares++; $display("FAIL midrst_async got %b want 0", obs_vec); end
    for (int i = 0; i < 3; i++) begin
      step();
      vectors++;
      if (obs_vec !== exp_vec) begin miscompares++; $display("FAIL midrst_low cyc %0d got %b want %b", i, obs_vec, exp_vec); end
    end
    reset = 1'b1;
    t0 = tick_cnt;
    while (tick_cnt - t0 < 22) begin
      step();
      vectors++;
      if (obs_vec !== exp_vec) begin miscompares++; $display("FAIL midrst_after got %b want %b", obs_vec, exp_vec); end
      pulses += key_pulse[3] ? 1 : 0;
    end
    vectors++;
    if (pulses != 1) begin miscompares++; $display("FAIL midrst_restart got %0d want 1", pulses); end
    key_raw[3] = 1'b0;
    for (int i = 0; i < 40; i++) begin
      step();
      vectors++;
      if (obs_vec !== exp_vec) begin miscompares++; $display("FAIL midrst_settle cyc %0d got %b want %b", i, obs_vec, exp_vec); end
    end
  endtask

  task automatic test_simultaneous();
    bit found = 1'b0;
    set_mode(0);
    key_raw[0] = 1'b1;
    key_raw[3] = 1'b1;
    for (int i = 0; i < 20 && !found; i++) begin
      step();
      vectors++;
      if (obs_vec !== exp_vec) begin miscompares++; $display("FAIL simul cyc %0d got %b want %b", i, obs_vec, exp_vec); end
      if (nr_pulse != 4'b0000) found = 1'b1;
    end
    vectors++;
    if (!found || nr_pulse !== 4'b1001 || key_pulse !== 4'b1001) begin
      miscompares++; $display("FAIL simul_pulse got %b/%b want 1001/1001", nr_pulse, key_pulse);
    end
    key_raw[0] = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      vectors++;
      if (obs_vec !== exp_vec) begin miscompares++; $display("FAIL simul_rel0 cyc %0d got %b want %b", i, obs_vec, exp_vec); end
    end
    vectors++;
    if (key_busy !== 1'b1 || key_state !== 4'b1000) begin
      miscompares++; $display("FAIL simul_busy got %b/%b want 1/1000", key_busy, key_state);
    end
    key_raw[3] = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      vectors++;
      if (obs_vec !== exp_vec) begin miscompares++; $display("FAIL simul_rel3 cyc %0d got %b want %b", i, obs_vec, exp_vec); end
    end
    vectors++;
    if (key_busy !== 1'b0 || nr_busy !== 1'b0) begin
      miscompares++; $display("FAIL simul_idle got %b/%b want 0/0", key_busy, nr_busy);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 3000; i++) begin
      if (i == 0) set_mode(2);
      if (i == 1500) set_mode(0);
      for (int k = 0; k < NK; k++)
        if ($urandom_range(0, 39) == 0) key_raw[k] = ~key_raw[k];
      step();
      vectors++;
      if (obs_vec !== exp_vec) begin miscompares++; $display("FAIL random cyc %0d got %b want %b", i, obs_vec, exp_vec); end
    end
    key_raw = '0;
    for (int i = 0; i < 60; i++) begin
      step();
      vectors++;
      if (obs_vec !== exp_vec) begin miscompares++; $display("FAIL random_settle cyc %0d got %b want %b", i, obs_vec, exp_vec); end
    end
  endtask

  initial begin
    for (int k = 0; k < NK; k++) m_n[k] = 0;
    test_reset();
    test_clean_press();
    test_bounce();
    test_auto_repeat();
    test_release_in_delay();
    test_reset_mid_repeat();
    test_simultaneous();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
